// File: rtl/io_seg_scheduler_pkg.sv
// io_seg_pkg: shared constants, state type and helpers for the 7-segment
// display scheduler. The IO decode and the status read path both use the
// address constants below, so they cannot drift apart.
package io_seg_pkg;

    // Default width of one display value and one second of hold at 100 MHz
    localparam int          SEG_DATA_W  = 24;
    localparam logic [31:0] SEG_HOLD_1S = 32'd100000000;

    // IO addresses: data write (enqueue), hold register write, status read
    localparam logic [31:0] SEG_DATA_ADDR   = 32'hFFFF_FC00;
    localparam logic [31:0] SEG_HOLD_ADDR   = 32'hFFFF_FC04;
    localparam logic [31:0] SEG_STATUS_ADDR = 32'hFFFF_FC08;

    // Scheduler state: nothing on display, or an entry is being shown
    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } seg_state_e;

    // A hold of 0 behaves like 1 cycle; the timer counts down to zero, so
    // the value loaded is one less than the display length
    function automatic logic [31:0] holdToTimer(input logic [31:0] hold);
        return (hold == 32'd0) ? 32'd0 : hold - 32'd1;
    endfunction

endpackage

// File: rtl/io_seg_scheduler_if.sv
// Bus between the IO block (master: write strobes, hold config, flush)
// and the segment scheduler (slave: display value and queue status).
interface io_seg_scheduler_if #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 32
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              flush;
    logic              hold_we;
    logic [31:0]       hold_cfg;
    logic [DATA_W-1:0] seg_out;
    logic              seg_valid;
    logic              full;
    logic              empty;
    logic [LVL_W-1:0]  level;
    logic              overflow;

    modport master (
        output wr_en, wr_data, flush, hold_we, hold_cfg,
        input  seg_out, seg_valid, full, empty, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, flush, hold_we, hold_cfg,
        output seg_out, seg_valid, full, empty, level, overflow
    );
endinterface

// File: rtl/io_seg_scheduler_fifo.sv
// seg_fifo: circular queue of display values with a separate level
// counter and registered full/empty/overflow status.
// Build option SEG_SCHED_OVERWRITE_EN: a write while full replaces the
// oldest queued entry instead of being dropped (overflow still pulses).
module seg_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          pushData_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          headData_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    logic              memWe;
    logic              popOk;
    logic              pushOk;

    // Next pointers/level: flush wins, a pop never makes room for a push
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = 1'b0;
        memWe      = 1'b0;
        popOk      = 1'b0;
        pushOk     = 1'b0;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            level_d = '0;
        end else begin
            popOk      = pop_i && !empty_q;
            pushOk     = push_i && !full_q;
            overflow_d = push_i && full_q;
`ifdef SEG_SCHED_OVERWRITE_EN
            memWe   = push_i;
            wrPtr_d = wrPtr_q + PTR_W'(push_i);
            rdPtr_d = rdPtr_q + PTR_W'(popOk) + PTR_W'(overflow_d);
`else
            memWe   = pushOk;
            wrPtr_d = wrPtr_q + PTR_W'(pushOk);
            rdPtr_d = rdPtr_q + PTR_W'(popOk);
`endif
            level_d = level_q + LVL_W'(pushOk) - LVL_W'(popOk);
        end
    end

    assign full_d  = (level_d == LVL_W'(DEPTH));
    assign empty_d = (level_d == '0);

    // Control and status registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are meaningless until written so no reset
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign headData_o = mem_q[rdPtr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = level_q;
    assign overflow_o = overflow_q;
endmodule

// File: rtl/io_seg_scheduler.sv
// io_seg_scheduler: queues CPU writes to the segment address and shows
// each value on seg_out for max(hold,1) cycles, back-to-back when more
// entries are waiting. Build option SEG_SCHED_OVERWRITE_EN selects the
// overwrite-oldest behaviour of the queue when it is full.
module io_seg_scheduler
    import io_seg_pkg::*;
#(
    parameter int          DATA_W   = SEG_DATA_W,
    parameter int          DEPTH    = 32,
    parameter logic [31:0] HOLD_RST = SEG_HOLD_1S
) (
    input  logic               clk,
    input  logic               rst_n,
    io_seg_scheduler_if.slave  bus
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    seg_state_e        state_q;
    logic [31:0]       timer_q;
    logic [31:0]       hold_q;
    logic [DATA_W-1:0] segOut_q;
    logic              segValid_q;
    logic [DATA_W-1:0] headData;
    logic [LVL_W-1:0]  fifoLevel;
    logic              pop;

    // Take the head when idle or when the current entry's time is up;
    // uses the registered level, so a same-cycle push is not seen yet
    assign pop = !bus.flush && (fifoLevel != '0) &&
                 ((state_q == IDLE) || (timer_q == 32'd0));

    seg_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (bus.flush),
        .push_i     (bus.wr_en),
        .pushData_i (bus.wr_data),
        .pop_i      (pop),
        .headData_o (headData),
        .full_o     (bus.full),
        .empty_o    (bus.empty),
        .level_o    (fifoLevel),
        .overflow_o (bus.overflow)
    );

    // Display FSM with hold register, timer and registered segment outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            hold_q     <= HOLD_RST;
            segOut_q   <= '0;
            segValid_q <= 1'b0;
        end else begin
            if (bus.hold_we) begin
                hold_q <= bus.hold_cfg;
            end
            if (bus.flush) begin
                state_q    <= IDLE;
                timer_q    <= '0;
                segOut_q   <= '0;
                segValid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (pop) begin
                            segOut_q   <= headData;
                            segValid_q <= 1'b1;
                            timer_q    <= holdToTimer(hold_q);
                            state_q    <= SHOW;
                        end else begin
                            segOut_q   <= '0;
                            segValid_q <= 1'b0;
                        end
                    end
                    SHOW: begin
                        if (timer_q != 32'd0) begin
                            timer_q <= timer_q - 32'd1;
                        end else if (pop) begin
                            segOut_q <= headData;
                            timer_q  <= holdToTimer(hold_q);
                        end else begin
                            segOut_q   <= '0;
                            segValid_q <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.seg_out   = segOut_q;
    assign bus.seg_valid = segValid_q;
    assign bus.level     = fifoLevel;
endmodule

// File: doc/io_seg_scheduler.md
Name: io_seg_scheduler

Overview:
- Sequences the 7-segment display path: CPU writes to the segment IO address are queued, and each queued value is shown for a programmable number of cycles.
- Replaces the ad-hoc VRAM front/back logic that currently lives inside the IO block.
- Sits between the IO address decode (seg write strobe) and the segment driver.
- Exposes full/empty/level status so software can poll it through an IO read address.

Parameters:
- DATA_W, 24, width of one display value.
- DEPTH, 32, queue entries; must be a power of two ≥ 2.
- HOLD_RST, 100000000, reset value of the hold register (one second at 100 MHz).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  enqueue strobe (IOWrite && address == seg address).
- wr_data  input  DATA_W  value to enqueue.
- flush  input  1  discard the queue and the current display.
- hold_we  input  1  load hold_cfg into the hold register.
- hold_cfg  input  32  display time per entry, in cycles.
- seg_out  output  DATA_W  value driven to the segment driver.
- seg_valid  output  1  seg_out holds a queued value.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- level  output  $clog2(DEPTH)+1  number of queued entries, excluding the one on display.
- overflow  output  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (asynchronous):
  - seg_out=0, seg_valid=0, level=0, empty=1, full=0, overflow=0.
  - Pointers=0, hold register=HOLD_RST, timer=0, state=IDLE.
  - Reset mid-display aborts immediately; the queue is lost.
- Queue:
  - Circular buffer with wr_ptr/rd_ptr of log2(DEPTH) bits; both wrap DEPTH-1→0.
  - level is a separate counter.
- Write rules:
  - wr_en && !full: store at wr_ptr, advance wr_ptr, level+1.
  - wr_en && full: write dropped, overflow=1 for one cycle, no state change.
  - A pop in the same cycle does not make room.
- State IDLE:
  - seg_out=0, seg_valid=0.
  - If level != 0: pop the head into seg_out, timer ← max(hold,1)-1, seg_valid=1, go to SHOW.
- State SHOW:
  - If timer != 0: timer-1.
  - If timer == 0 and level != 0: pop the next entry back-to-back (no blank cycle) and reload the timer.
  - If timer == 0 and level == 0: seg_out=0, seg_valid=0, go to IDLE.
- Display timing:
  - Each entry is shown for exactly max(hold,1) cycles.
  - hold is sampled when the entry is popped.
- Latency: a write at edge N into an empty, idle block gives seg_valid=1 and seg_out=data after edge N+1.
- Simultaneous push and pop: both occur; level unchanged.
- Push with level==0 in the same cycle as a pop from SHOW: the pop sees the old level (0), so no pop; the new entry is popped next cycle.
- hold_we:
  - The register updates at the edge.
  - It does not alter the running timer; it affects the next pop.
  - hold_cfg=0 is stored as-is and treated as 1 at load.
- flush:
  - Highest priority after reset.
  - Pointers=0, level=0, seg_out=0, seg_valid=0, timer=0, state=IDLE.
  - A concurrent wr_en is dropped without an overflow pulse.
  - A concurrent hold_we is still applied.
- Status outputs: full, empty and level are registered, consistent with the post-edge level.

Optional Feature:
- Macro: SEG_SCHED_OVERWRITE_EN.
- Defined: wr_en while full overwrites the oldest queued entry.
  - The write stores at wr_ptr, and rd_ptr and wr_ptr both advance; level stays DEPTH.
  - overflow still pulses to flag the lost entry.
- Undefined: the drop-newest behaviour above.

Decomposition:
- Package io_seg_pkg holds:
  - SEG_DATA_W=24 and SEG_HOLD_1S=100000000.
  - State typedef {IDLE, SHOW}.
  - The IO address constants for seg-data, seg-hold and seg-status so the decode and the status read share them.
- One natural sub-module: seg_fifo.
  - Contains: storage, pointers, level, full/empty, overwrite option.
  - The scheduler FSM and timer stay in io_seg_scheduler.

Test Plan:
(bench uses DEPTH=4, HOLD_RST=4)
- Basic display: after reset write 0x000123 once → seg_valid rises one edge later, seg_out=0x000123 for 4 cycles, then 0 with seg_valid=0.
- Back-to-back: write 0x11, 0x22, 0x33 on consecutive cycles → each shown 4 cycles, no blank gap, total 12 cycles valid; level goes 1,1,2,... and returns to 0.
- Full/overflow: while the first entry is on display, write 5 more values → level=4, full=1, fifth write gives an overflow pulse.
  - Displayed sequence omits the fifth value.
  - With SEG_SCHED_OVERWRITE_EN, the sequence omits the oldest queued value instead.
- Hold reprogram: hold_we with hold_cfg=2 mid-display → current entry finishes its 4 cycles, next entry shows 2 cycles; hold_cfg=0 → entries last 1 cycle.
- Flush: flush with level=3 and same-cycle wr_en → next cycle level=0, empty=1, seg_out=0, no overflow; a later write displays normally.
- Async reset: assert rst_n low mid-SHOW between clock edges → outputs clear immediately without a clock edge; hold returns to 4.
